// File: rtl/uart_tx_frame.sv
// UART transmitter: one parallel word per accepted request becomes a serial frame
// of start bit, LSB-first data, optional parity bit and one stop bit.
module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_reg;
  logic [CW-1:0]           baud_cnt_reg;
  logic [IW-1:0]           bit_idx_reg;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    par_en_reg;
  logic                    parity_reg;
  logic                    tx_reg;
  logic                    busy_reg;
  logic                    baud_wrap;

  assign baud_wrap = (baud_cnt_reg == BAUD_LAST);
  assign TX_OUT    = tx_reg;
  assign BUSY      = busy_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          if (DATA_VALID) begin
            shift_reg   <= P_DATA;
            par_en_reg  <= PAR_EN;
            parity_reg  <= (^P_DATA) ^ PAR_TYP;
            bit_idx_reg <= '0;
            state_reg   <= START;
            tx_reg      <= 1'b0;
            busy_reg    <= 1'b1;
          end
        end
        default: begin
          if (baud_wrap) baud_cnt_reg <= '0;
          else           baud_cnt_reg <= baud_cnt_reg + 1'b1;
          // The line only changes on a baud wrap, so each bit lasts CLKS_PER_BIT cycles.
          if (baud_wrap) begin
            case (state_reg)
              START: begin
                state_reg   <= DATA;
                bit_idx_reg <= '0;
                tx_reg      <= shift_reg[0];
                shift_reg   <= shift_reg >> 1;
              end
              DATA: begin
                if (bit_idx_reg == BIT_LAST) begin
                  if (par_en_reg) begin
                    state_reg <= PARITY;
                    tx_reg    <= parity_reg;
                  end else begin
                    state_reg <= STOP;
                    tx_reg    <= 1'b1;
                  end
                end else begin
                  bit_idx_reg <= bit_idx_reg + 1'b1;
                  tx_reg      <= shift_reg[0];
                  shift_reg   <= shift_reg >> 1;
                end
              end
              PARITY: begin
                state_reg <= STOP;
                tx_reg    <= 1'b1;
              end
              STOP: begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                tx_reg    <= 1'b1;
              end
              default: begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                tx_reg    <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomised scoreboard bench for uart_tx_frame: one instance at 4 clocks per bit
// and one at 1 clock per bit, each with its own reference model and line monitor.
module tb_uart_tx_frame;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par_typ;
  } exp_t;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, required %0h", name, inst, act, req);
    end
  endtask

  function automatic int frame_bits(input bit par_en);
    return par_en ? 11 : 10;
  endfunction

  // Frame bit k of a frame built from the protocol rules.
  function automatic bit exp_bit(input exp_t e, input int k);
    int ones;
    ones = $countones(e.data);
    if (k == 0) return 1'b0;
    if (k <= 8) return e.data[k-1];
    if (k == 9 && e.par_en) return bit'(ones % 2) ^ e.par_typ;
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int CPB = (gi == 0) ? 4 : 1;

    logic       rst, dv, par_en, par_typ, tx, busy;
    logic [7:0] pdata;
    exp_t       exp_q[$];
    exp_t       cur;
    int         rem;
    bit         rst_edge;
    bit         armed;
    bit         done_i;
    bit         in_frame;
    bit         prev_busy;
    int         cyc;
    bit         rx[12];

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
      .CLK(clk), .RST(rst), .P_DATA(pdata), .DATA_VALID(dv),
      .PAR_EN(par_en), .PAR_TYP(par_typ), .TX_OUT(tx), .BUSY(busy)
    );

    // Reference model: a request is taken only when the previous frame is over.
    initial begin
      rem = 0; rst_edge = 1'b1; armed = 1'b0;
      forever begin
        @(posedge clk);
        armed    = 1'b1;
        rst_edge = rst;
        if (rst) rem = 0;
        else if (rem == 0 && dv) begin
          exp_q.push_back(exp_t'{pdata, par_en, par_typ});
          rem = frame_bits(par_en) * CPB;
        end else if (rem > 0) rem--;
      end
    end

    // Monitor: compares every busy cycle of the line and decodes mid-bit samples.
    initial begin
      in_frame = 1'b0; prev_busy = 1'b0; cyc = 0;
      forever begin
        @(negedge clk);
        if (!armed) continue;
        if (rst_edge) begin
          check(busy == 1'b0 && tx == 1'b1, "reset_state", gi, {busy, tx}, 32'h1);
          in_frame  = 1'b0;
          prev_busy = 1'b0;
          continue;
        end
        if (busy && !prev_busy) begin
          check(exp_q.size() != 0, "unexpected_frame", gi, exp_q.size(), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            in_frame = 1'b1;
            cyc = 0;
          end
        end
        if (busy && in_frame) begin
          if (cyc >= frame_bits(cur.par_en) * CPB) begin
            check(1'b0, "busy_too_long", gi, cyc, frame_bits(cur.par_en) * CPB);
            in_frame = 1'b0;
          end else begin
            check(tx == exp_bit(cur, cyc / CPB), "tx_bit", gi, tx, exp_bit(cur, cyc / CPB));
            if (cyc % CPB == CPB / 2) rx[cyc / CPB] = tx;
            cyc++;
          end
        end
        if (!busy) begin
          check(tx == 1'b1, "idle_high", gi, tx, 1);
          if (in_frame) begin
            logic [7:0] rd;
            int         n;
            bit         ok;
            n = frame_bits(cur.par_en);
            check(cyc == n * CPB, "busy_len", gi, cyc, n * CPB);
            for (int k = 0; k < 8; k++) rd[k] = rx[k+1];
            ok = (rd == cur.data) && !rx[0] && rx[n-1];
            if (cur.par_en) ok = ok && ((($countones(rd) + int'(rx[9])) % 2) == int'(cur.par_typ));
            check(ok, "loopback", gi, rd, cur.data);
            in_frame = 1'b0;
          end
        end
        prev_busy = busy;
      end
    end

    // Stimulus: directed frames, held request, mid-frame reset, then random traffic.
    initial begin
      logic [7:0] d_tab [4];
      bit         pe_tab[4];
      bit         pt_tab[4];
      d_tab  = '{8'hA5, 8'h03, 8'h03, 8'hFF};
      pe_tab = '{1'b0, 1'b1, 1'b1, 1'b1};
      pt_tab = '{1'b0, 1'b0, 1'b1, 1'b1};
      done_i = 1'b0;
      rst = 1'b1; dv = 1'b1; pdata = 8'hA5; par_en = 1'b0; par_typ = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; dv = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 4; i++) begin
        #1 pdata = d_tab[i]; par_en = pe_tab[i]; par_typ = pt_tab[i]; dv = 1'b1;
        @(posedge clk);
        #1 dv = 1'b0; pdata = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
        repeat (12 * CPB + 3) @(posedge clk);
      end

      #1 dv = 1'b1;
      repeat (3 * 12 * CPB) begin
        @(posedge clk);
        #1 pdata = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
      end
      dv = 1'b0;
      repeat (12 * CPB + 3) @(posedge clk);

      #1 pdata = 8'($urandom); par_en = 1'($urandom); dv = 1'b1;
      @(posedge clk);
      #1 dv = 1'b0;
      repeat (5 * CPB) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 pdata = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom); dv = 1'b1;
      @(posedge clk);
      #1 dv = 1'b0;
      repeat (12 * CPB + 3) @(posedge clk);

      for (int i = 0; i < 40; i++) begin
        #1 pdata = 8'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom); dv = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 dv = 1'b0;
        repeat ($urandom_range(0, 12 * CPB)) @(posedge clk);
      end
      repeat (13 * CPB + 4) @(posedge clk);
      check(exp_q.size() == 0, "frames_outstanding", gi, exp_q.size(), 0);
      done_i = 1'b1;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(g_dut[0].done_i && g_dut[1].done_i) && waited < 60000) begin
      @(posedge clk);
      waited++;
    end
    check(g_dut[0].done_i && g_dut[1].done_i, "timeout", 0, waited, 60000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
